// File: rtl/wb_commit_arbiter_pkg.sv
// rtl/wb_commit_arbiter_pkg.sv - shared widths and trace entry type for the commit arbiter
package wb_commit_arbiter_pkg;

    localparam int SINGLE_WORD = 32;
    localparam int GPR_NUM     = 5;

    typedef struct packed {
        logic [SINGLE_WORD-1:0] pc;
        logic [GPR_NUM-1:0]     wnum;
        logic [SINGLE_WORD-1:0] wdata;
        logic                   wen;
    } trace_entry_t;

    localparam int TRACE_ENTRY_W = $bits(trace_entry_t);

    // A write to r0 is architecturally invisible, so it never shows as a trace write
    function automatic logic [3:0] trace_wen(input trace_entry_t e);
        return {4{e.wen && (e.wnum != '0)}};
    endfunction

endpackage

// File: rtl/wb_commit_arbiter_fifo.sv
// rtl/wb_commit_arbiter_fifo.sv - generic 2-write/1-read in-order FIFO (commit_fifo)
module commit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq0_valid_i,
    input  logic [WIDTH-1:0]         enq0_data_i,
    input  logic                     enq1_valid_i,
    input  logic [WIDTH-1:0]         enq1_data_i,
    input  logic                     deq_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] slot1;

    // Slot 0 is older than slot 1; a lone slot-1 write lands at the write pointer
    always_comb begin
        mem_d = mem_q;
        slot1 = wr_ptr_q + PTR_W'(enq0_valid_i);
        if (enq0_valid_i) begin
            mem_d[wr_ptr_q] = enq0_data_i;
        end
        if (enq1_valid_i) begin
            mem_d[slot1] = enq1_data_i;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(enq0_valid_i) + PTR_W'(enq1_valid_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(deq_i);
        count_d  = count_q + CNT_W'(enq0_valid_i) + CNT_W'(enq1_valid_i) - CNT_W'(deq_i);
    end

    // Pointer and occupancy state; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is live
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) count_d <= DEPTH_C);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst) deq_i |-> (count_q != '0));

endmodule

// File: rtl/wb_commit_arbiter.sv
// rtl/wb_commit_arbiter.sv - dual-issue writeback to single-lane debug trace commit arbiter
module wb_commit_arbiter
    import wb_commit_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lane0_valid_i,
    input  logic [31:0]            lane0_pc_i,
    input  logic [4:0]             lane0_wnum_i,
    input  logic [31:0]            lane0_wdata_i,
    input  logic                   lane0_wen_i,
    input  logic                   lane1_valid_i,
    input  logic [31:0]            lane1_pc_i,
    input  logic [4:0]             lane1_wnum_i,
    input  logic [31:0]            lane1_wdata_i,
    input  logic                   lane1_wen_i,
    output logic                   arb_allowin_o,
    output logic [31:0]            debug_wb_pc,
    output logic [3:0]             debug_wb_rf_wen,
    output logic [4:0]             debug_wb_rf_wnum,
    output logic [31:0]            debug_wb_rf_wdata,
    output logic [$clog2(DEPTH):0] arb_count_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] ALLOW_MAX = CNT_W'(DEPTH - 2);

    trace_entry_t            lane0_e, lane1_e, head_e, emit_e;
    logic [TRACE_ENTRY_W-1:0] fifo_head;
    logic [TRACE_ENTRY_W-1:0] enq0_data, enq1_data;
    logic                    enq0_valid, enq1_valid, deq;
    logic [CNT_W-1:0]        count;
    logic                    acc0, acc1, emit;

    logic [31:0] pc_q, pc_d;
    logic [3:0]  wen_q, wen_d;
    logic [4:0]  wnum_q, wnum_d;
    logic [31:0] wdata_q, wdata_d;

    assign lane0_e = '{pc: lane0_pc_i, wnum: lane0_wnum_i, wdata: lane0_wdata_i, wen: lane0_wen_i};
    assign lane1_e = '{pc: lane1_pc_i, wnum: lane1_wnum_i, wdata: lane1_wdata_i, wen: lane1_wen_i};
    assign head_e  = fifo_head;

    // Conservative allowin from registered occupancy: always room for a full pair
    assign arb_allowin_o = (count <= ALLOW_MAX);
    assign acc0 = lane0_valid_i && arb_allowin_o;
    assign acc1 = lane1_valid_i && arb_allowin_o;

    // Pick one entry to emit (buffer head first, else oldest accepted lane) and enqueue the rest in order
    always_comb begin
        enq0_valid = 1'b0;
        enq0_data  = lane0_e;
        enq1_valid = 1'b0;
        enq1_data  = lane1_e;
        deq        = 1'b0;
        emit       = 1'b0;
        emit_e     = head_e;
        if (count != '0) begin
            deq        = 1'b1;
            emit       = 1'b1;
            emit_e     = head_e;
            enq0_valid = acc0;
            enq1_valid = acc1;
        end else if (acc0) begin
            emit       = 1'b1;
            emit_e     = lane0_e;
            enq0_valid = acc1;
            enq0_data  = lane1_e;
        end else if (acc1) begin
            emit       = 1'b1;
            emit_e     = lane1_e;
        end
    end

    commit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TRACE_ENTRY_W)
    ) u_commit_fifo (
        .clk          (clk),
        .rst          (rst),
        .enq0_valid_i (enq0_valid),
        .enq0_data_i  (enq0_data),
        .enq1_valid_i (enq1_valid),
        .enq1_data_i  (enq1_data),
        .deq_i        (deq),
        .head_o       (fifo_head),
        .count_o      (count)
    );

    // Trace fields load on emit; without an emit only the write enable is cleared
    always_comb begin
        pc_d    = pc_q;
        wnum_d  = wnum_q;
        wdata_d = wdata_q;
        wen_d   = '0;
        if (emit) begin
            pc_d    = emit_e.pc;
            wnum_d  = emit_e.wnum;
            wdata_d = emit_e.wdata;
            wen_d   = trace_wen(emit_e);
        end
    end

    // Registered trace port
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= '0;
            wen_q   <= '0;
            wnum_q  <= '0;
            wdata_q <= '0;
        end else begin
            pc_q    <= pc_d;
            wen_q   <= wen_d;
            wnum_q  <= wnum_d;
            wdata_q <= wdata_d;
        end
    end

    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_wen   = wen_q;
    assign debug_wb_rf_wnum  = wnum_q;
    assign debug_wb_rf_wdata = wdata_q;
    assign arb_count_o       = count;

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// tb/tb_wb_commit_arbiter.sv - directed self-checking bench for wb_commit_arbiter
module tb_wb_commit_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lane0_valid_i, lane0_wen_i, lane1_valid_i, lane1_wen_i;
    logic [31:0] lane0_pc_i, lane0_wdata_i, lane1_pc_i, lane1_wdata_i;
    logic [4:0]  lane0_wnum_i, lane1_wnum_i;
    logic        arb_allowin_o;
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [2:0]  arb_count_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_commit_arbiter #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .lane0_valid_i     (lane0_valid_i),
        .lane0_pc_i        (lane0_pc_i),
        .lane0_wnum_i      (lane0_wnum_i),
        .lane0_wdata_i     (lane0_wdata_i),
        .lane0_wen_i       (lane0_wen_i),
        .lane1_valid_i     (lane1_valid_i),
        .lane1_pc_i        (lane1_pc_i),
        .lane1_wnum_i      (lane1_wnum_i),
        .lane1_wdata_i     (lane1_wdata_i),
        .lane1_wen_i       (lane1_wen_i),
        .arb_allowin_o     (arb_allowin_o),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .arb_count_o       (arb_count_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_lane0(input logic v, input logic [31:0] pc, input logic [4:0] wnum,
                             input logic [31:0] wdata, input logic wen);
        lane0_valid_i = v; lane0_pc_i = pc; lane0_wnum_i = wnum;
        lane0_wdata_i = wdata; lane0_wen_i = wen;
    endtask

    task automatic set_lane1(input logic v, input logic [31:0] pc, input logic [4:0] wnum,
                             input logic [31:0] wdata, input logic wen);
        lane1_valid_i = v; lane1_pc_i = pc; lane1_wnum_i = wnum;
        lane1_wdata_i = wdata; lane1_wen_i = wen;
    endtask

    task automatic idle_lanes();
        set_lane0(1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        set_lane1(1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_trace(input string tag, input logic [31:0] pc, input logic [3:0] wen,
                               input logic [2:0] cnt);
        check({tag, "_pc"}, debug_wb_pc, pc);
        check({tag, "_wen"}, 32'(debug_wb_rf_wen), 32'(wen));
        check({tag, "_count"}, 32'(arb_count_o), 32'(cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, emitted, cnt_m, n_in, stalls;
        logic exp_allow, do_emit;

        // reset then idle
        idle_lanes();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_allowin", 32'(arb_allowin_o), 32'd1);
            check("idle_count", 32'(arb_count_o), 32'd0);
            check("idle_wen", 32'(debug_wb_rf_wen), 32'd0);
            check("idle_pc", debug_wb_pc, 32'd0);
            check("idle_wnum", 32'(debug_wb_rf_wnum), 32'd0);
            check("idle_wdata", debug_wb_rf_wdata, 32'd0);
        end

        // single commit into an empty buffer
        set_lane0(1'b1, 32'hBFC0_0000, 5'd3, 32'h1234_5678, 1'b1);
        tick();
        idle_lanes();
        check_trace("single", 32'hBFC0_0000, 4'hF, 3'd0);
        check("single_wnum", 32'(debug_wb_rf_wnum), 32'd3);
        check("single_wdata", debug_wb_rf_wdata, 32'h1234_5678);
        tick();
        check_trace("single_after", 32'hBFC0_0000, 4'h0, 3'd0);

        // pair into an empty buffer; lane 1 writes r0 so its wen is masked
        set_lane0(1'b1, 32'h100, 5'd4, 32'hAAAA_0001, 1'b1);
        set_lane1(1'b1, 32'h104, 5'd0, 32'hBBBB_0002, 1'b1);
        tick();
        idle_lanes();
        check_trace("pair_t1", 32'h100, 4'hF, 3'd1);
        check("pair_t1_wdata", debug_wb_rf_wdata, 32'hAAAA_0001);
        tick();
        check_trace("pair_t2", 32'h104, 4'h0, 3'd0);
        check("pair_t2_wnum", 32'(debug_wb_rf_wnum), 32'd0);
        check("pair_t2_wdata", debug_wb_rf_wdata, 32'hBBBB_0002);
        tick();
        check("pair_t3_wen", 32'(debug_wb_rf_wen), 32'd0);

        // back-to-back pairs: 8 pairs, writeback holds lanes while allowin is low
        sent = 0; emitted = 0; cnt_m = 0; stalls = 0;
        for (int cyc = 0; cyc < 40 && emitted < 16; cyc++) begin
            if (sent < 8) begin
                set_lane0(1'b1, 32'h1000 + 32'(8 * sent), 5'd5, (32'h1000 + 32'(8 * sent)) ^ 32'h5A5A_0000, 1'b1);
                set_lane1(1'b1, 32'h1004 + 32'(8 * sent), 5'd6, (32'h1004 + 32'(8 * sent)) ^ 32'h5A5A_0000, 1'b1);
            end else begin
                idle_lanes();
            end
            exp_allow = (cnt_m <= DEPTH - 2);
            check("b2b_allowin", 32'(arb_allowin_o), 32'(exp_allow));
            if (sent < 8 && !exp_allow) stalls++;
            n_in = (exp_allow && sent < 8) ? 2 : 0;
            do_emit = (cnt_m > 0) || (n_in > 0);
            if (do_emit) cnt_m = cnt_m + n_in - 1;
            if (n_in > 0) sent++;
            tick();
            check("b2b_count", 32'(arb_count_o), 32'(cnt_m));
            if (do_emit) begin
                check("b2b_pc", debug_wb_pc, 32'h1000 + 32'(4 * emitted));
                check("b2b_wnum", 32'(debug_wb_rf_wnum), (emitted % 2 == 0) ? 32'd5 : 32'd6);
                check("b2b_wdata", debug_wb_rf_wdata, (32'h1000 + 32'(4 * emitted)) ^ 32'h5A5A_0000);
                check("b2b_wen", 32'(debug_wb_rf_wen), 32'hF);
                emitted++;
            end else begin
                check("b2b_wen_idle", 32'(debug_wb_rf_wen), 32'd0);
            end
        end
        idle_lanes();
        check("b2b_emitted", 32'(emitted), 32'd16);
        check("b2b_sent", 32'(sent), 32'd8);
        check("b2b_stalls", 32'(stalls), 32'd5);
        tick();
        check("b2b_drained_wen", 32'(debug_wb_rf_wen), 32'd0);
        check("b2b_drained_count", 32'(arb_count_o), 32'd0);

        // lane1-only into an empty buffer
        set_lane1(1'b1, 32'h200, 5'd7, 32'h2222_0000, 1'b1);
        tick();
        idle_lanes();
        check_trace("l1_empty", 32'h200, 4'hF, 3'd0);
        check("l1_empty_wnum", 32'(debug_wb_rf_wnum), 32'd7);

        // lane1-only behind a buffered entry
        set_lane0(1'b1, 32'h300, 5'd8, 32'h3000_0000, 1'b1);
        set_lane1(1'b1, 32'h304, 5'd9, 32'h3040_0000, 1'b1);
        tick();
        check_trace("l1_buf_t1", 32'h300, 4'hF, 3'd1);
        set_lane0(1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
        set_lane1(1'b1, 32'h208, 5'd10, 32'h2080_0000, 1'b0);
        tick();
        idle_lanes();
        check_trace("l1_buf_t2", 32'h304, 4'hF, 3'd1);
        tick();
        check_trace("l1_buf_t3", 32'h208, 4'h0, 3'd0);
        check("l1_buf_t3_wdata", debug_wb_rf_wdata, 32'h2080_0000);

        // fill to count 3, then reset aborts everything
        for (int k = 0; k < 3; k++) begin
            set_lane0(1'b1, 32'h400 + 32'(8 * k), 5'd11, 32'h4000_0000, 1'b1);
            set_lane1(1'b1, 32'h404 + 32'(8 * k), 5'd12, 32'h4040_0000, 1'b1);
            tick();
        end
        idle_lanes();
        check("fill_count", 32'(arb_count_o), 32'd3);
        check("fill_allowin", 32'(arb_allowin_o), 32'd0);
        check("fill_pc", debug_wb_pc, 32'h408);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_trace("rst_abort", 32'h0, 4'h0, 3'd0);
        check("rst_abort_allowin", 32'(arb_allowin_o), 32'd1);
        check("rst_abort_wnum", 32'(debug_wb_rf_wnum), 32'd0);
        check("rst_abort_wdata", debug_wb_rf_wdata, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_trace("post_rst", 32'h0, 4'h0, 3'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_commit_arbiter.md
# wb_commit_arbiter

Dual-issue trace commit arbiter at the end of the writeback stage. Accepts up to two retiring instructions per cycle, lane 0 older and lane 1 younger, and holds them in a small in-order buffer. It drives them one per cycle onto the single-lane difftest/debug trace port (`debug_wb_*`). When the buffer cannot absorb a full pair, it back-pressures writeback through `arb_allowin_o`.

## Interface
Parameters:
- `DEPTH`, default 4: buffer entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `lane0_valid_i`  in  1  lane 0 (older) retires this cycle.
- `lane0_pc_i`  in  32  lane 0 PC.
- `lane0_wnum_i`  in  5  lane 0 destination GPR; 0 means no write.
- `lane0_wdata_i`  in  32  lane 0 write data.
- `lane0_wen_i`  in  1  lane 0 writes the register file.
- `lane1_valid_i`, `lane1_pc_i`, `lane1_wnum_i`, `lane1_wdata_i`, `lane1_wen_i`  in  1/32/5/32/1  same signals for lane 1 (younger).
- `arb_allowin_o`  out  1  writeback may present a pair this cycle.
- `debug_wb_pc`  out  32  trace PC, registered.
- `debug_wb_rf_wen`  out  4  trace write enable, registered.
- `debug_wb_rf_wnum`  out  5  trace GPR number, registered.
- `debug_wb_rf_wdata`  out  32  trace data, registered.
- `arb_count_o`  out  $clog2(DEPTH)+1  current buffer occupancy.

## Operation
- Acceptance: lane X is accepted in a cycle iff `laneX_valid_i && arb_allowin_o`. Writeback must hold its lanes while `arb_allowin_o` is 0. Lane 1 may be valid without lane 0; it is then treated as the oldest commit.
- `arb_allowin_o = (count <= DEPTH-2)`. It is derived from registered count only, with no combinational path from inputs. It is deliberately conservative: a pop in the same cycle does not raise it.
- Order: output order is always buffered entries first, then accepted lane 0, then accepted lane 1.
- Emit: each cycle exactly one entry is taken for output if any is available.
  - If the buffer is non-empty, the head is popped.
  - Otherwise, if an accepted commit exists, the oldest accepted commit bypasses straight into the output registers.
  - Any remaining accepted commit(s) are enqueued.
- Output fields on emit:
  - `debug_wb_pc`, `debug_wb_rf_wnum` and `debug_wb_rf_wdata` take the entry values.
  - `debug_wb_rf_wen = {4{wen && wnum!=0}}`.
- No emit in a cycle: `debug_wb_rf_wen <= 0`; pc, wnum and wdata hold their last values.
- Count: `count_next = count + enq_n - deq`, where `enq_n` ∈ {0,1,2} excludes a bypassed commit and `deq` ∈ {0,1}. Pointers wrap modulo DEPTH. Count never exceeds DEPTH by construction; overflow is an assertion failure.
- Reset (rst=0 at an edge): all of the following are cleared, aborting any in-flight entries.
  - count, rd/wr pointers
  - `debug_wb_pc`, `debug_wb_rf_wen`, `debug_wb_rf_wnum` and `debug_wb_rf_wdata` are all set to 0.
  - `arb_allowin_o` is 1 in the first cycle after reset.
- Entries are never flushed: retired instructions are architectural.

## Timing
- Empty buffer: the oldest accepted commit appears on `debug_wb_*` 1 cycle after acceptance. The second commit of the same pair appears 2 cycles after.
- Non-empty buffer: an entry at position k (0 = head) is emitted k+1 cycles later, provided no reset intervenes.
- Throughput: 1 trace entry per cycle, sustained. Sustained paired input therefore stalls writeback roughly every other cycle.
- `arb_allowin_o` changes only on clock edges.
- Simultaneous accept-pair and pop at count = DEPTH-2: allowed. The result is count = DEPTH-1, and allowin drops the next cycle.

## Structure
- Shared package: `SINGLE_WORD` (32) and `GPR_NUM` (5) widths, plus the `trace_entry_t` struct {pc, wnum, wdata, wen}.
- Sub-module `commit_fifo`: a generic 2-write/1-read in-order FIFO.
  - Interface: enq0/enq1 with ordered slots, deq, head, count.
  - The top level holds the bypass mux, the allowin logic and the output registers.

## Test plan
- Reset then idle:
  - `arb_allowin_o`=1, `arb_count_o`=0 and `debug_wb_rf_wen`=0 every cycle.
  - pc, wnum and wdata are 0.
- Single commit into an empty buffer: lane0 {pc=0xBFC00000, wnum=3, wdata=0x12345678, wen=1} at cycle t. Next cycle the trace shows that entry with wen=4'hF, then wen=0; count stays 0.
- Pair into an empty buffer:
  - lane0 pc=0x100 wnum=4, lane1 pc=0x104 wnum=0 wen=1.
  - Trace shows pc 0x100 with wen=F at t+1, then pc 0x104 with wen=0 at t+2 (wnum=0 masks wen).
  - count=1 at t+1.
- Back-to-back pairs for 8 cycles with DEPTH=4:
  - allowin drops once count reaches 3.
  - All 16 commits are emitted in program order with no loss or duplicate.
  - Writeback holds its lanes while allowin=0.
- Lane1-only commit: pc=0x200 with lane0 invalid. It is emitted at t+1 and ordered correctly behind previously buffered entries.
- Reset asserted with count=3: the next cycle has count=0, allowin=1 and wen=0. No stale entry is ever emitted afterward.
